register_file: RTL and testbench



---
 rtl/register_file_if.sv | 23 ++
 rtl/register_file.sv | 60 ++++++
 tb/tb_register_file.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Decode-stage register file bus: rs/rt read indices, rd writeback port, and the two read results.
interface register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    modport master (
        output rs, rt, rd, regWrite, writeData,
        input  readData1, readData2
    );

    modport slave (
        input  rs, rt, rd, regWrite, writeData,
        output readData1, readData2
    );
endinterface

// File: rtl/register_file.sv
// MIPS GPR file: 32x32, two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] stored1_c;
    logic [DATA_WIDTH-1:0] stored2_c;

    // Writes to r0 are dropped so the zero register can never be disturbed.
    assign wr_en_c = bus.regWrite && (bus.rd != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en_c) begin
            regs_d[bus.rd] = bus.writeData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        stored1_c = (bus.rs == '0) ? '0 : regs_q[bus.rs];
        stored2_c = (bus.rt == '0) ? '0 : regs_q[bus.rt];
    end

`ifdef RF_BYPASS_EN
    // Write-through: pending writeback data appears on a matching read port before the edge.
    logic fwd1_c;
    logic fwd2_c;

    assign fwd1_c = wr_en_c && (bus.rd == bus.rs);
    assign fwd2_c = wr_en_c && (bus.rd == bus.rt);

    assign bus.readData1 = rst ? '0 : (fwd1_c ? bus.writeData : stored1_c);
    assign bus.readData2 = rst ? '0 : (fwd2_c ? bus.writeData : stored2_c);
`else
    assign bus.readData1 = rst ? '0 : stored1_c;
    assign bus.readData2 = rst ? '0 : stored2_c;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed register-file scenarios, then random traffic vs an array model.
module tb_register_file;
    logic clk;
    logic rst;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value from the architectural view: reset, r0, optional forwarding, stored word.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (rst) return 32'h0;
        if (idx == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (rf.regWrite && rf.rd == idx) return rf.writeData;
`endif
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rf.rd = a; rf.writeData = d; rf.regWrite = 1'b1;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        @(negedge clk);
        rf.regWrite = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [4:0] a, input logic [4:0] b);
        rf.rs = a; rf.rt = b;
        #1;
        check({tag, "_rd1"}, rf.readData1, exp_read(a));
        check({tag, "_rd2"}, rf.readData2, exp_read(b));
    endtask

    initial begin
        logic [31:0] hazard_exp;
        logic        hold_rst;

        rst = 1'b1;
        rf.rs = 5'd0; rf.rt = 5'd0; rf.rd = 5'd0;
        rf.regWrite = 1'b0; rf.writeData = 32'h0;
        clear_model();

        #12;
        rf.rs = 5'd5; rf.rt = 5'd31; #1;
        check("reset_rs5", rf.readData1, 32'h0);
        check("reset_rt31", rf.readData2, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Prior contents must be wiped by a reset pulse that sees no clock edge.
        do_write(5'd5, 32'h1234_5678);
        do_write(5'd31, 32'hCAFE_F00D);
        read_both("prewrite", 5'd5, 5'd31);
        check("prewrite_abs5", rf.readData1, 32'h1234_5678);
        #1 rst = 1'b1;
        #1;
        check("async_rst_rs5", rf.readData1, 32'h0);
        check("async_rst_rt31", rf.readData2, 32'h0);
        #1 rst = 1'b0;
        clear_model();
        #1;
        check("after_pulse_rs5", rf.readData1, 32'h0);
        check("after_pulse_rt31", rf.readData2, 32'h0);

        do_write(5'd1, 32'd9);
        rf.rs = 5'd0; rf.rt = 5'd1; #1;
        check("basic_rt1", rf.readData2, 32'd9);
        check("basic_rs0", rf.readData1, 32'h0);

        do_write(5'd0, 32'hDEAD_BEEF);
        rf.rs = 5'd0; rf.rt = 5'd0; #1;
        check("r0_write_rs", rf.readData1, 32'h0);
        check("r0_write_rt", rf.readData2, 32'h0);
        @(negedge clk);
        rf.rd = 5'd0; rf.writeData = 32'hDEAD_BEEF; rf.regWrite = 1'b1; rf.rs = 5'd0;
        #1;
        check("r0_no_forward", rf.readData1, 32'h0);
        @(negedge clk);
        rf.regWrite = 1'b0;

        do_write(5'd3, 32'd7);
        @(negedge clk);
        rf.rd = 5'd3; rf.writeData = 32'd55; rf.regWrite = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rf.rs = 5'd3; #1;
        check("wr_disable_r3", rf.readData1, 32'd7);

        do_write(5'd4, 32'd1);
        @(negedge clk);
        rf.rd = 5'd4; rf.rs = 5'd4; rf.rt = 5'd4; rf.writeData = 32'd2; rf.regWrite = 1'b1;
        #1;
`ifdef RF_BYPASS_EN
        hazard_exp = 32'd2;
`else
        hazard_exp = 32'd1;
`endif
        check("hazard_pre_rd1", rf.readData1, hazard_exp);
        check("hazard_pre_rd2", rf.readData2, hazard_exp);
        @(posedge clk);
        model[4] = 32'd2;
        #1;
        check("hazard_post_rd1", rf.readData1, 32'd2);
        check("hazard_post_rd2", rf.readData2, 32'd2);
        @(negedge clk);
        rf.regWrite = 1'b0;

        // Reset held across an edge: the coincident write is lost.
        @(negedge clk);
        rf.rd = 5'd6; rf.writeData = 32'h6666_6666; rf.regWrite = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rf.regWrite = 1'b0;
        clear_model();
        rf.rs = 5'd6; rf.rt = 5'd4; #1;
        check("rst_edge_write_lost", rf.readData1, 32'h0);
        check("rst_edge_clears_r4", rf.readData2, 32'h0);

        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 3 + 1));
        for (int i = 0; i < 32; i++) begin
            rf.rs = 5'(i); rf.rt = 5'(31 - i); #1;
            check($sformatf("sweep_rs%0d", i), rf.readData1, (i == 0) ? 32'h0 : 32'(i * 3 + 1));
            check($sformatf("sweep_rt%0d", 31 - i), rf.readData2,
                  (i == 31) ? 32'h0 : 32'((31 - i) * 3 + 1));
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            rf.rs = 5'(i); rf.rt = 5'(i); #1;
            check($sformatf("sweep_rst_rs%0d", i), rf.readData1, 32'h0);
            check($sformatf("sweep_rst_rt%0d", i), rf.readData2, 32'h0);
        end

        // Random traffic against the array model, with occasional reset across an edge.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rf.rd = 5'($urandom_range(0, 31));
            rf.rs = ($urandom_range(0, 3) == 0) ? rf.rd : 5'($urandom_range(0, 31));
            rf.rt = ($urandom_range(0, 3) == 0) ? rf.rd : 5'($urandom_range(0, 31));
            rf.writeData = $urandom;
            rf.regWrite = 1'($urandom_range(0, 1));
            hold_rst = ($urandom_range(0, 39) == 0);
            rst = hold_rst;
            #1;
            check("rand_pre_rd1", rf.readData1, exp_read(rf.rs));
            check("rand_pre_rd2", rf.readData2, exp_read(rf.rt));
            @(posedge clk);
            if (hold_rst) clear_model();
            else if (rf.regWrite && rf.rd != 5'd0) model[rf.rd] = rf.writeData;
            #1;
            check("rand_post_rd1", rf.readData1, exp_read(rf.rs));
            check("rand_post_rd2", rf.readData2, exp_read(rf.rt));
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
